// File: rtl/fw_rule_sram_responder_pkg.sv
// Shared rule-store definitions: depth, end-of-rules marker, rule word layout and port FSM encodings.
// Imported by the responder, its RAM, and the firewall's rule-consult logic.
package fw_rule_sram_responder_pkg;

  localparam int RULE_DEPTH = 16;
  localparam int FIM_REGRAS = 4;

  // Rule word layout: {ip[63:32], port[31:16], reserved[15:8], action[7:0]}
  localparam int RULE_IP_LSB     = 32;
  localparam int RULE_IP_W       = 32;
  localparam int RULE_PORT_LSB   = 16;
  localparam int RULE_PORT_W     = 16;
  localparam int RULE_ACTION_LSB = 0;
  localparam int RULE_ACTION_W   = 8;

  typedef struct packed {
    logic [RULE_IP_W-1:0]     ip;
    logic [RULE_PORT_W-1:0]   port;
    logic [7:0]               rsvd;
    logic [RULE_ACTION_W-1:0] action;
  } rule_t;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_ACK  = 1'b1;

endpackage

// File: rtl/fw_rule_mem.sv
// Single-port synchronous rule RAM, write-first, one registered read cycle.
// No flow control: every cycle performs either a write or a read of addr.
module fw_rule_mem
  import fw_rule_sram_responder_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_BITS  = $clog2(RULE_DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_BITS-1:0]  addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_BITS];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
      rdata     <= wdata;
    end else begin
      rdata     <= mem[addr];
    end
  end

endmodule

// File: rtl/fw_rule_sram_responder.sv
// SRAM rule-port responder: arbitrates read/write requests into a local rule RAM, ack one cycle after accept.
// Read data returns READ_LATENCY cycles after rd_ack, in order; requesters hold req until their ack.
module fw_rule_sram_responder
  import fw_rule_sram_responder_pkg::*;
#(
  parameter int DATA_WIDTH      = 64,
  parameter int SRAM_ADDR_WIDTH = 19,
  parameter int MEM_ADDR_BITS   = 4,
  parameter int READ_LATENCY    = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       rd_req,
  input  logic [SRAM_ADDR_WIDTH-1:0] rd_addr,
  output logic                       rd_ack,
  output logic [DATA_WIDTH-1:0]      rd_data,
  output logic                       rd_vld,
  input  logic                       wr_req,
  input  logic [SRAM_ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0]      wr_data,
  output logic                       wr_ack,
  output logic                       oob_err,
  output logic [15:0]                rd_count,
  output logic [15:0]                wr_count
);

  logic [0:0]               rd_state, wr_state;
  logic                     prio_wr;
  logic                     rd_elig, wr_elig, rd_grant, wr_grant;
  logic                     rd_oob, wr_oob, rd_oob_q;
  logic                     mem_we;
  logic [MEM_ADDR_BITS-1:0] mem_addr;
  logic [DATA_WIDTH-1:0]    mem_q;
  logic [READ_LATENCY-1:0]  vld_pipe;
  logic [DATA_WIDTH-1:0]    dat_pipe [READ_LATENCY];

  assign rd_ack = (rd_state == ST_ACK);
  assign wr_ack = (wr_state == ST_ACK);

  // The ack cycle masks the port so a held request is not taken twice.
  assign rd_elig  = rd_req && !rd_ack;
  assign wr_elig  = wr_req && !wr_ack;
  assign wr_grant = wr_elig && (!rd_elig || prio_wr);
  assign rd_grant = rd_elig && (!wr_elig || !prio_wr);

  assign rd_oob = |rd_addr[SRAM_ADDR_WIDTH-1:MEM_ADDR_BITS];
  assign wr_oob = |wr_addr[SRAM_ADDR_WIDTH-1:MEM_ADDR_BITS];

  assign mem_we   = wr_grant && !wr_oob;
  assign mem_addr = wr_grant ? wr_addr[MEM_ADDR_BITS-1:0] : rd_addr[MEM_ADDR_BITS-1:0];

  fw_rule_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_BITS  (MEM_ADDR_BITS)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .addr  (mem_addr),
    .wdata (wr_data),
    .rdata (mem_q)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_state <= ST_IDLE;
      wr_state <= ST_IDLE;
      prio_wr  <= 1'b1;
      rd_oob_q <= 1'b0;
      oob_err  <= 1'b0;
      rd_count <= '0;
      wr_count <= '0;
    end else begin
      rd_state <= rd_grant ? ST_ACK : ST_IDLE;
      wr_state <= wr_grant ? ST_ACK : ST_IDLE;
      if (rd_elig && wr_elig) prio_wr <= !prio_wr;
      rd_oob_q <= rd_grant && rd_oob;
      if ((rd_grant && rd_oob) || (wr_grant && wr_oob)) oob_err <= 1'b1;
      if (rd_grant) rd_count <= rd_count + 16'd1;
      if (wr_grant) wr_count <= wr_count + 16'd1;
    end
  end

  // RAM output is valid during the rd_ack cycle; out-of-range reads and idle slots carry zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_pipe <= '0;
      for (int i = 0; i < READ_LATENCY; i++) dat_pipe[i] <= '0;
    end else begin
      vld_pipe[0] <= rd_ack;
      dat_pipe[0] <= (rd_ack && !rd_oob_q) ? mem_q : '0;
      for (int i = 1; i < READ_LATENCY; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        dat_pipe[i] <= dat_pipe[i-1];
      end
    end
  end

  assign rd_vld  = vld_pipe[READ_LATENCY-1];
  assign rd_data = dat_pipe[READ_LATENCY-1];

endmodule

// File: tb/tb_fw_rule_sram_responder.sv
// Directed bench for fw_rule_sram_responder: read-data scoreboard on the negedge plus hand-computed vectors.
module tb_fw_rule_sram_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        rd_req = 1'b0;
  logic [18:0] rd_addr = '0;
  logic        rd_ack;
  logic [63:0] rd_data;
  logic        rd_vld;
  logic        wr_req = 1'b0;
  logic [18:0] wr_addr = '0;
  logic [63:0] wr_data = '0;
  logic        wr_ack;
  logic        oob_err;
  logic [15:0] rd_count;
  logic [15:0] wr_count;

  fw_rule_sram_responder dut (
    .clk      (clk),
    .reset    (reset),
    .rd_req   (rd_req),
    .rd_addr  (rd_addr),
    .rd_ack   (rd_ack),
    .rd_data  (rd_data),
    .rd_vld   (rd_vld),
    .wr_req   (wr_req),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .wr_ack   (wr_ack),
    .oob_err  (oob_err),
    .rd_count (rd_count),
    .wr_count (wr_count)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  int          vld_cnt  = 0;
  logic [63:0] exp_q [$];
  logic [63:0] sweep_dat [5];

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset === 1'b1) begin
      if (rd_vld === 1'b1) begin
        vld_cnt++;
        if (exp_q.size() == 0) check("rd_vld_unexpected", 64'(rd_vld), 64'd0);
        else check("rd_data", rd_data, exp_q.pop_front());
      end else begin
        check("rd_data_idle", rd_data, 64'd0);
      end
    end
  end

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic do_write(input logic [18:0] a, input logic [63:0] d, output int n);
    wr_addr = a;
    wr_data = d;
    wr_req  = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (wr_ack !== 1'b1 && n < 10);
    wr_req = 1'b0;
    check("wr_ack_seen", 64'(wr_ack), 64'd1);
  endtask

  task automatic issue_read(input logic [18:0] a, input logic [63:0] e, output int n);
    exp_q.push_back(e);
    rd_addr = a;
    rd_req  = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (rd_ack !== 1'b1 && n < 10);
    rd_req = 1'b0;
    check("rd_ack_seen", 64'(rd_ack), 64'd1);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    check("drain", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int          n;
    int          base;
    logic [5:0]  pattern;
    logic [63:0] new2, new1, dead;

    sweep_dat[0] = 64'h0A00_0001_0050_0001;
    sweep_dat[1] = 64'h0A00_0002_01BB_0002;
    sweep_dat[2] = 64'hC0A8_0101_0016_0001;
    sweep_dat[3] = 64'hAC10_0003_0035_0002;
    sweep_dat[4] = 64'h0000_0000_0000_00FF;
    new2 = 64'hC0A8_0002_0017_0001;
    new1 = 64'h0A0A_0A0A_1F90_0002;
    dead = 64'hDEAD_BEEF_0000_0050;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_rd_ack",   64'(rd_ack),   64'd0);
    check("rst_wr_ack",   64'(wr_ack),   64'd0);
    check("rst_rd_vld",   64'(rd_vld),   64'd0);
    check("rst_oob_err",  64'(oob_err),  64'd0);
    check("rst_rd_data",  rd_data,       64'd0);
    check("rst_rd_count", 64'(rd_count), 64'd0);
    check("rst_wr_count", 64'(wr_count), 64'd0);
    reset = 1'b1;
    @(negedge clk);

    // Single write then read with exact latencies
    do_write(19'd3, dead, n);
    check("wr_ack_lat", 64'(n), 64'd1);
    issue_read(19'd3, dead, n);
    check("rd_ack_lat", 64'(n), 64'd1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (rd_vld !== 1'b1 && n < 8);
    check("rd_vld_lat", 64'(n), 64'd2);
    check("t1_rd_count", 64'(rd_count), 64'd1);
    check("t1_wr_count", 64'(wr_count), 64'd1);
    drain();

    // Rule sweep: fill 0..4, back-to-back reads
    for (int i = 0; i < 5; i++) do_write(19'(i), sweep_dat[i], n);
    base = vld_cnt;
    for (int i = 0; i < 5; i++) issue_read(19'(i), sweep_dat[i], n);
    drain();
    check("sweep_vld_cnt", 64'(vld_cnt - base), 64'd5);
    check("sweep_rd_count", 64'(rd_count), 64'd6);
    check("sweep_wr_count", 64'(wr_count), 64'd6);

    // Simultaneous request after reset: write wins, then read sees new data
    apply_reset();
    wr_addr = 19'd2; wr_data = new2; wr_req = 1'b1;
    rd_addr = 19'd2; rd_req = 1'b1;
    exp_q.push_back(new2);
    @(negedge clk);
    check("sim_wr_first", 64'(wr_ack), 64'd1);
    check("sim_rd_wait",  64'(rd_ack), 64'd0);
    wr_req = 1'b0;
    @(negedge clk);
    check("sim_rd_next",  64'(rd_ack), 64'd1);
    check("sim_wr_idle",  64'(wr_ack), 64'd0);
    rd_req = 1'b0;
    drain();

    // Priority now favours read: read returns old contents, write follows
    wr_addr = 19'd1; wr_data = new1; wr_req = 1'b1;
    rd_addr = 19'd1; rd_req = 1'b1;
    exp_q.push_back(sweep_dat[1]);
    @(negedge clk);
    check("prio_rd_first", 64'(rd_ack), 64'd1);
    check("prio_wr_wait",  64'(wr_ack), 64'd0);
    rd_req = 1'b0;
    @(negedge clk);
    check("prio_wr_next",  64'(wr_ack), 64'd1);
    wr_req = 1'b0;
    issue_read(19'd1, new1, n);
    drain();
    check("prio_rd_count", 64'(rd_count), 64'd3);
    check("prio_wr_count", 64'(wr_count), 64'd2);

    // Out-of-range accesses
    do_write(19'h10, 64'hFFFF_FFFF_FFFF_FFFF, n);
    check("oob_wr_flag", 64'(oob_err), 64'd1);
    issue_read(19'd0, sweep_dat[0], n);
    issue_read(19'h7FFFF, 64'd0, n);
    drain();
    repeat (3) @(negedge clk);
    check("oob_sticky", 64'(oob_err), 64'd1);
    check("oob_wr_count", 64'(wr_count), 64'd3);
    apply_reset();
    check("oob_cleared", 64'(oob_err), 64'd0);

    // Held read request for 6 cycles: accepts on alternate cycles
    repeat (3) exp_q.push_back(sweep_dat[4]);
    rd_addr = 19'd4;
    rd_req  = 1'b1;
    pattern = '0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      pattern = {pattern[4:0], rd_ack};
    end
    rd_req = 1'b0;
    check("held_ack_pattern", 64'(pattern), 64'b101010);
    check("held_rd_count", 64'(rd_count), 64'd3);
    drain();

    // Reset one cycle after rd_ack drops the in-flight read
    issue_read(19'd3, sweep_dat[3], n);
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    @(negedge clk);
    reset = 1'b1;
    base = vld_cnt;
    repeat (5) @(negedge clk);
    check("midrst_no_vld", 64'(vld_cnt - base), 64'd0);
    check("midrst_rd_count", 64'(rd_count), 64'd0);
    check("midrst_wr_count", 64'(wr_count), 64'd0);
    issue_read(19'd3, sweep_dat[3], n);
    issue_read(19'd2, new2, n);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
